// File: rtl/block_stream_gen_if.sv
// Command handshake and keyword-stream outputs of block_stream_gen.
// The master side issues word commands; the slave side emits characters and nesting status.
interface block_stream_gen_if #(
    parameter int unsigned DepthW = 8
);
    logic              cmd_valid;
    logic              cmd_op;
    logic [4:0]        cmd_case;
    logic              cmd_ready;
    logic [7:0]        out_char;
    logic              out_valid;
    logic [DepthW-1:0] depth;
    logic              underflow;
    logic              balanced;

    modport master (
        output cmd_valid, cmd_op, cmd_case,
        input  cmd_ready, out_char, out_valid, depth, underflow, balanced
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_case,
        output cmd_ready, out_char, out_valid, depth, underflow, balanced
    );
endinterface

// File: rtl/block_stream_gen.sv
// Emits "begin " / "end " one character per clock, with per-letter case masks,
// and tracks begin/end nesting depth with a sticky underflow flag.
module block_stream_gen #(
    parameter int unsigned DepthW = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    block_stream_gen_if.slave bus_io
);
    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    localparam logic [DepthW-1:0] DepthMax  = {DepthW{1'b1}};
    localparam logic [2:0]        LastBegin = 3'd5;
    localparam logic [2:0]        LastEnd   = 3'd3;

    state_e            state_q;
    logic [2:0]        idx_q;
    logic              op_q;
    logic [4:0]        case_q;
    logic [7:0]        char_q;
    logic              valid_q;
    logic [DepthW-1:0] depth_q;
    logic              underflow_q;

    logic [2:0] last_idx;
    logic [2:0] idx_next;
    logic       at_last;
    logic       at_space_edge;
    logic       ready;
    logic       accept;

    // Character at position idx of the word; positions past the letters are the space.
    function automatic logic [7:0] word_char(input logic op, input logic [4:0] cs,
                                             input logic [2:0] idx);
        logic [7:0] ch;
        logic [7:0] mask;
        ch   = 8'h20;
        mask = 8'h00;
        if (!op) begin
            mask = {3'b000, cs};
            case (idx)
                3'd0:    ch = "b";
                3'd1:    ch = "e";
                3'd2:    ch = "g";
                3'd3:    ch = "i";
                3'd4:    ch = "n";
                default: ch = 8'h20;
            endcase
        end else begin
            mask = {5'b00000, cs[2:0]};
            case (idx)
                3'd0:    ch = "e";
                3'd1:    ch = "n";
                3'd2:    ch = "d";
                default: ch = 8'h20;
            endcase
        end
        if (ch != 8'h20 && mask[idx]) begin
            ch = ch & 8'hDF;
        end
        return ch;
    endfunction

    always_comb begin
        last_idx      = op_q ? LastEnd : LastBegin;
        idx_next      = idx_q + 3'd1;
        at_last       = (state_q == StEmit) && (idx_q == last_idx);
        at_space_edge = (state_q == StEmit) && (idx_q == last_idx - 3'd1);
        ready         = !reset_i && ((state_q == StIdle) || at_last);
        accept        = bus_io.cmd_valid && ready;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            op_q        <= 1'b0;
            case_q      <= 5'd0;
            char_q      <= 8'h00;
            valid_q     <= 1'b0;
            depth_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            // Nesting changes on the edge that puts the trailing space on the output.
            if (at_space_edge) begin
                if (!op_q) begin
                    if (depth_q != DepthMax) begin
                        depth_q <= depth_q + DepthW'(1);
                    end
                end else if (depth_q != '0) begin
                    depth_q <= depth_q - DepthW'(1);
                end else begin
                    underflow_q <= 1'b1;
                end
            end

            if (accept) begin
                state_q <= StEmit;
                idx_q   <= 3'd0;
                op_q    <= bus_io.cmd_op;
                case_q  <= bus_io.cmd_case;
                char_q  <= word_char(bus_io.cmd_op, bus_io.cmd_case, 3'd0);
                valid_q <= 1'b1;
            end else if (state_q == StEmit) begin
                if (at_last) begin
                    state_q <= StIdle;
                    idx_q   <= 3'd0;
                    char_q  <= 8'h00;
                    valid_q <= 1'b0;
                end else begin
                    idx_q  <= idx_next;
                    char_q <= word_char(op_q, case_q, idx_next);
                end
            end
        end
    end

    assign bus_io.cmd_ready = ready;
    assign bus_io.out_char  = char_q;
    assign bus_io.out_valid = valid_q;
    assign bus_io.depth     = depth_q;
    assign bus_io.underflow = underflow_q;
    assign bus_io.balanced  = (depth_q == '0) && !underflow_q;
endmodule
